// File: rtl/cache_types.sv
// Cache-line and physical-memory geometry shared by the cache hierarchy.
package cache_types;

    localparam int CACHE_LINE_BITS = 256;
    localparam int PMEM_BEAT_BITS  = 64;
    localparam int BURST_BEATS     = CACHE_LINE_BITS / PMEM_BEAT_BITS;

    typedef logic [CACHE_LINE_BITS-1:0] cache_line_t;
    typedef logic [PMEM_BEAT_BITS-1:0]  pmem_beat_t;

endpackage

// File: rtl/rv32i_types.sv
// Core RV32I scalar types shared across the memory hierarchy.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/cacheline_adaptor.sv
// Serves 256-bit line reads/writes as four-beat 64-bit bursts to physical memory,
// holding the line completion until the requester releases its request.
module cacheline_adaptor
    import rv32i_types::*;
    import cache_types::*;
#(
    parameter int BEATS = BURST_BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  rv32i_word   addr_in,
    input  logic        read_in,
    input  logic        write_in,
    input  cache_line_t wdata_in,
    output cache_line_t rdata_out,
    output logic        mem_resp_out,
    output rv32i_word   pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output pmem_beat_t  pmem_wdata,
    input  pmem_beat_t  pmem_rdata,
    input  logic        pmem_resp
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    logic [1:0]  state;
    logic [1:0]  cnt;
    cache_line_t line_q;
    cache_line_t wline_q;
    rv32i_word   addr_q;
    logic [7:0]  beat_lsb;

    assign beat_lsb = {cnt, 6'b0};

    // A simultaneous read and write request services the read; the write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            line_q  <= '0;
            wline_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_in || write_in) begin
                        state   <= read_in ? RD_BURST : WR_BURST;
                        addr_q  <= addr_in & ~32'h1F;
                        wline_q <= wdata_in;
                        cnt     <= 2'd0;
                    end
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        line_q[beat_lsb +: PMEM_BEAT_BITS] <= pmem_rdata;
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) state <= DONE;
                    end
                end
                WR_BURST: begin
                    if (pmem_resp) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) state <= DONE;
                    end
                end
                default: begin
                    if (!read_in && !write_in) state <= IDLE;
                end
            endcase
        end
    end

    assign rdata_out    = line_q;
    assign mem_resp_out = (state == DONE);
    assign pmem_address = addr_q;
    assign pmem_read    = (state == RD_BURST);
    assign pmem_write   = (state == WR_BURST);
    assign pmem_wdata   = pmem_write ? wline_q[beat_lsb +: PMEM_BEAT_BITS] : '0;

endmodule
